branch_target_buffer: RTL and testbench

- 2-way set-associative BTB in the fetch stage, sitting directly upstream of the branch predictor.
- Each cycle it looks up all N fetch PCs combinationally and returns per-slot hit bits and predicted targets.
- The hit bits drive the predictor's btb_hits input, which gates its taken predictions. The targets drive fetch redirection.
- Execute writes or updates entries on taken-branch resolution. It invalidates entries when a PC resolves as a non-branch (alias/self-modifying cleanup).

---
 rtl/branch_target_buffer_if.sv | 24 ++
 rtl/branch_target_buffer.sv | 103 ++++++++++
 tb/tb_branch_target_buffer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_if.sv
// Fetch/execute side bundle of the branch target buffer: lookup PCs and results,
// plus the write (taken branch) and invalidate (non-branch) update ports.
interface branch_target_buffer_if #(
   parameter int unsigned N = 4
);
   logic [N-1:0][31:0] PCs_out;
   logic [N-1:0]       btb_hits;
   logic [N-1:0][31:0] btb_targets;
   logic               wr_valid;
   logic [31:0]        wr_PC;
   logic [31:0]        wr_target;
   logic               inv_valid;
   logic [31:0]        inv_PC;

   modport master (
      output PCs_out, wr_valid, wr_PC, wr_target, inv_valid, inv_PC,
      input  btb_hits, btb_targets
   );

   modport slave (
      input  PCs_out, wr_valid, wr_PC, wr_target, inv_valid, inv_PC,
      output btb_hits, btb_targets
   );
endinterface

// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer: N combinational lookup ports,
// one write port (taken-branch resolution) and one invalidate port, 1-bit LRU per set.
module branch_target_buffer #(
   parameter int unsigned N        = 4,
   parameter int unsigned BTB_SETS = 32,
   parameter int unsigned TAG_BITS = 10,
   parameter int unsigned IDX_BITS = $clog2(BTB_SETS)
) (
   input logic                   clock,
   input logic                   reset,
   branch_target_buffer_if.slave btb
);
   localparam int unsigned TAG_LO = IDX_BITS + 2;
   localparam int unsigned TAG_HI = IDX_BITS + TAG_BITS + 1;

   logic [1:0]          valid_q  [BTB_SETS];
   logic [TAG_BITS-1:0] tag_q    [BTB_SETS][2];
   logic [31:0]         target_q [BTB_SETS][2];
   logic [BTB_SETS-1:0] lru_q;

   for (genvar i = 0; i < N; i++) begin : g_lookup
      logic [IDX_BITS-1:0] idx;
      logic [TAG_BITS-1:0] tag;
      logic                hit0;
      logic                hit1;
      logic                unused_pc_bits;

      assign idx  = btb.PCs_out[i][TAG_LO-1:2];
      assign tag  = btb.PCs_out[i][TAG_HI:TAG_LO];
      assign hit0 = valid_q[idx][0] && (tag_q[idx][0] == tag);
      assign hit1 = valid_q[idx][1] && (tag_q[idx][1] == tag);
      assign unused_pc_bits = ^{btb.PCs_out[i][1:0], btb.PCs_out[i][31:TAG_HI+1]};

      // Way 0 takes precedence should both ways ever hold the same tag.
      assign btb.btb_hits[i]    = hit0 | hit1;
      assign btb.btb_targets[i] = hit0 ? target_q[idx][0] :
                                  hit1 ? target_q[idx][1] : '0;
   end

   logic [IDX_BITS-1:0] wr_idx;
   logic [TAG_BITS-1:0] wr_tag;
   logic [IDX_BITS-1:0] inv_idx;
   logic [TAG_BITS-1:0] inv_tag;
   logic [1:0]          inv_hit;
   logic [1:0]          wr_hit;
   logic [1:0]          wr_valid_post;
   logic                wr_way;
   logic                unused_upd_bits;

   assign wr_idx  = btb.wr_PC[TAG_LO-1:2];
   assign wr_tag  = btb.wr_PC[TAG_HI:TAG_LO];
   assign inv_idx = btb.inv_PC[TAG_LO-1:2];
   assign inv_tag = btb.inv_PC[TAG_HI:TAG_LO];
   assign unused_upd_bits = ^{btb.wr_PC[1:0], btb.wr_PC[31:TAG_HI+1],
                              btb.inv_PC[1:0], btb.inv_PC[31:TAG_HI+1]};

   // Allocation sees the valid bits after a same-set invalidate, so a freed way
   // can be refilled in the same cycle; tag matching uses the pre-invalidate view
   // so a same-PC write/invalidate updates the entry in place and keeps it valid.
   always_comb begin
      inv_hit       = '0;
      wr_hit        = '0;
      wr_valid_post = valid_q[wr_idx];
      wr_way        = 1'b0;
      inv_hit[0] = btb.inv_valid && valid_q[inv_idx][0] && (tag_q[inv_idx][0] == inv_tag);
      inv_hit[1] = btb.inv_valid && valid_q[inv_idx][1] && (tag_q[inv_idx][1] == inv_tag);
      wr_hit[0]  = valid_q[wr_idx][0] && (tag_q[wr_idx][0] == wr_tag);
      wr_hit[1]  = valid_q[wr_idx][1] && (tag_q[wr_idx][1] == wr_tag);
      if (inv_idx == wr_idx) begin
         wr_valid_post = valid_q[wr_idx] & ~inv_hit;
      end
      if (wr_hit[0]) begin
         wr_way = 1'b0;
      end else if (wr_hit[1]) begin
         wr_way = 1'b1;
      end else if (!wr_valid_post[0]) begin
         wr_way = 1'b0;
      end else if (!wr_valid_post[1]) begin
         wr_way = 1'b1;
      end else begin
         wr_way = lru_q[wr_idx];
      end
   end

   // Write updates come after the invalidate clears so the write wins on overlap.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q  <= '{default: '0};
         tag_q    <= '{default: '0};
         target_q <= '{default: '0};
         lru_q    <= '0;
      end else begin
         if (inv_hit[0]) valid_q[inv_idx][0] <= 1'b0;
         if (inv_hit[1]) valid_q[inv_idx][1] <= 1'b0;
         if (btb.wr_valid) begin
            valid_q[wr_idx][wr_way]  <= 1'b1;
            tag_q[wr_idx][wr_way]    <= wr_tag;
            target_q[wr_idx][wr_way] <= btb.wr_target;
            lru_q[wr_idx]            <= ~wr_way;
         end
      end
   end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scenario bench for branch_target_buffer: each task plays a step table, queues the
// expected lookup result when a step is driven and checks it mid-cycle.
module tb_branch_target_buffer;
   localparam int N = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   branch_target_buffer_if #(.N(N)) btb_bus ();

   branch_target_buffer #(.N(N)) dut (
      .clock (clock),
      .reset (reset),
      .btb   (btb_bus)
   );

   typedef struct {
      logic               rst;
      logic [N-1:0][31:0] pcs;
      logic               wv;
      logic [31:0]        wpc;
      logic [31:0]        wt;
      logic               iv;
      logic [31:0]        ipc;
      logic               chk;
      logic [N-1:0]       hits;
      logic [N-1:0][31:0] tg;
   } step_t;

   typedef struct {
      logic [N-1:0]       hits;
      logic [N-1:0][31:0] tg;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [N-1:0][31:0] p4(input logic [31:0] a, b, c, d);
      logic [N-1:0][31:0] r;
      r[0] = a; r[1] = b; r[2] = c; r[3] = d;
      return r;
   endfunction

   function automatic step_t st(input logic rst, input logic [N-1:0][31:0] pcs,
                                input logic wv, input logic [31:0] wpc, wt,
                                input logic iv, input logic [31:0] ipc,
                                input logic chk, input logic [N-1:0] hits,
                                input logic [N-1:0][31:0] tg);
      step_t s;
      s.rst = rst; s.pcs = pcs; s.wv = wv; s.wpc = wpc; s.wt = wt;
      s.iv = iv; s.ipc = ipc; s.chk = chk; s.hits = hits; s.tg = tg;
      return s;
   endfunction

   function automatic step_t wr(input logic [31:0] pc, t);
      return st(1'b0, '0, 1'b1, pc, t, 1'b0, '0, 1'b0, '0, '0);
   endfunction

   function automatic step_t inv(input logic [31:0] pc);
      return st(1'b0, '0, 1'b0, '0, '0, 1'b1, pc, 1'b0, '0, '0);
   endfunction

   function automatic step_t lk(input logic [N-1:0][31:0] pcs, input logic [N-1:0] hits,
                                input logic [N-1:0][31:0] tg);
      return st(1'b0, pcs, 1'b0, '0, '0, 1'b0, '0, 1'b1, hits, tg);
   endfunction

   task automatic apply(input step_t s);
      @(posedge clock);
      #1;
      reset             = s.rst;
      btb_bus.PCs_out   = s.pcs;
      btb_bus.wr_valid  = s.wv;
      btb_bus.wr_PC     = s.wpc;
      btb_bus.wr_target = s.wt;
      btb_bus.inv_valid = s.iv;
      btb_bus.inv_PC    = s.ipc;
      if (s.chk) sb.push_back('{hits: s.hits, tg: s.tg});
   endtask

   task automatic test_reset();
      step_t s[$];
      exp_t  e;
      s.push_back(st(1'b1, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0));
      s.push_back(st(1'b1, p4(32'h100, 32'h104, 32'h108, 32'h10C), 1'b0, '0, '0,
                     1'b0, '0, 1'b1, 4'b0000, '0));
      s.push_back(lk(p4(32'h100, 32'h104, 32'h108, 32'h10C), 4'b0000, '0));
      foreach (s[k]) begin
         apply(s[k]);
         @(negedge clock);
         if (s[k].chk) begin
            e = sb.pop_front();
            for (int i = 0; i < N; i++) begin
               n_cmp++;
               if (btb_bus.btb_hits[i] !== e.hits[i] || btb_bus.btb_targets[i] !== e.tg[i]) begin
                  n_bad++;
                  $display("FAIL reset step%0d slot%0d: got hit=%b target=%h, expected hit=%b target=%h",
                           k, i, btb_bus.btb_hits[i], btb_bus.btb_targets[i], e.hits[i], e.tg[i]);
               end
            end
         end
      end
   endtask

   task automatic test_write_visibility();
      step_t s[$];
      exp_t  e;
      s.push_back(st(1'b0, p4(32'h100, 32'h104, 32'h100, 32'h104), 1'b1, 32'h100, 32'h200,
                     1'b0, '0, 1'b1, 4'b0000, '0));
      s.push_back(lk(p4(32'h100, 32'h104, 32'h103, 32'h20100), 4'b1101,
                     p4(32'h200, 32'h0, 32'h200, 32'h200)));
      foreach (s[k]) begin
         apply(s[k]);
         @(negedge clock);
         if (s[k].chk) begin
            e = sb.pop_front();
            for (int i = 0; i < N; i++) begin
               n_cmp++;
               if (btb_bus.btb_hits[i] !== e.hits[i] || btb_bus.btb_targets[i] !== e.tg[i]) begin
                  n_bad++;
                  $display("FAIL write_visibility step%0d slot%0d: got hit=%b target=%h, expected hit=%b target=%h",
                           k, i, btb_bus.btb_hits[i], btb_bus.btb_targets[i], e.hits[i], e.tg[i]);
               end
            end
         end
      end
   endtask

   task automatic test_replacement();
      step_t s[$];
      exp_t  e;
      // Set 17: A, B, C, D differ only in tag.
      s.push_back(wr(32'h0C4, 32'hA00));
      s.push_back(wr(32'h144, 32'hB00));
      s.push_back(wr(32'h1C4, 32'hC00));
      s.push_back(lk(p4(32'h0C4, 32'h144, 32'h1C4, 32'h244), 4'b0110,
                     p4(32'h0, 32'hB00, 32'hC00, 32'h0)));
      s.push_back(wr(32'h244, 32'hD00));
      s.push_back(lk(p4(32'h0C4, 32'h144, 32'h1C4, 32'h244), 4'b1100,
                     p4(32'h0, 32'h0, 32'hC00, 32'hD00)));
      foreach (s[k]) begin
         apply(s[k]);
         @(negedge clock);
         if (s[k].chk) begin
            e = sb.pop_front();
            for (int i = 0; i < N; i++) begin
               n_cmp++;
               if (btb_bus.btb_hits[i] !== e.hits[i] || btb_bus.btb_targets[i] !== e.tg[i]) begin
                  n_bad++;
                  $display("FAIL replacement step%0d slot%0d: got hit=%b target=%h, expected hit=%b target=%h",
                           k, i, btb_bus.btb_hits[i], btb_bus.btb_targets[i], e.hits[i], e.tg[i]);
               end
            end
         end
      end
   endtask

   task automatic test_update_in_place();
      step_t s[$];
      exp_t  e;
      // Set 5: E tag 0, F tag 1, G tag 2.
      s.push_back(wr(32'h014, 32'h300));
      s.push_back(wr(32'h014, 32'h400));
      s.push_back(lk(p4(32'h014, 32'h094, 32'h114, 32'h014), 4'b1001,
                     p4(32'h400, 32'h0, 32'h0, 32'h400)));
      s.push_back(wr(32'h094, 32'h500));
      s.push_back(lk(p4(32'h014, 32'h094, 32'h114, 32'h000), 4'b0011,
                     p4(32'h400, 32'h500, 32'h0, 32'h0)));
      s.push_back(wr(32'h114, 32'h600));
      s.push_back(lk(p4(32'h014, 32'h094, 32'h114, 32'h000), 4'b0110,
                     p4(32'h0, 32'h500, 32'h600, 32'h0)));
      foreach (s[k]) begin
         apply(s[k]);
         @(negedge clock);
         if (s[k].chk) begin
            e = sb.pop_front();
            for (int i = 0; i < N; i++) begin
               n_cmp++;
               if (btb_bus.btb_hits[i] !== e.hits[i] || btb_bus.btb_targets[i] !== e.tg[i]) begin
                  n_bad++;
                  $display("FAIL update_in_place step%0d slot%0d: got hit=%b target=%h, expected hit=%b target=%h",
                           k, i, btb_bus.btb_hits[i], btb_bus.btb_targets[i], e.hits[i], e.tg[i]);
               end
            end
         end
      end
   endtask

   task automatic test_inv_write();
      step_t s[$];
      exp_t  e;
      logic [N-1:0][31:0] pcs;
      pcs = p4(32'h024, 32'h0A4, 32'h124, 32'h1A4);
      // Set 9: rewriting A leaves lru pointing at B's way.
      s.push_back(wr(32'h024, 32'h111));
      s.push_back(wr(32'h0A4, 32'h222));
      s.push_back(wr(32'h024, 32'h111));
      s.push_back(st(1'b0, '0, 1'b1, 32'h124, 32'h333, 1'b1, 32'h024, 1'b0, '0, '0));
      s.push_back(lk(pcs, 4'b0110, p4(32'h0, 32'h222, 32'h333, 32'h0)));
      s.push_back(st(1'b0, '0, 1'b1, 32'h124, 32'h444, 1'b1, 32'h124, 1'b0, '0, '0));
      s.push_back(lk(pcs, 4'b0110, p4(32'h0, 32'h222, 32'h444, 32'h0)));
      s.push_back(inv(32'h1A4));
      s.push_back(lk(pcs, 4'b0110, p4(32'h0, 32'h222, 32'h444, 32'h0)));
      s.push_back(inv(32'h0A4));
      s.push_back(lk(pcs, 4'b0100, p4(32'h0, 32'h0, 32'h444, 32'h0)));
      foreach (s[k]) begin
         apply(s[k]);
         @(negedge clock);
         if (s[k].chk) begin
            e = sb.pop_front();
            for (int i = 0; i < N; i++) begin
               n_cmp++;
               if (btb_bus.btb_hits[i] !== e.hits[i] || btb_bus.btb_targets[i] !== e.tg[i]) begin
                  n_bad++;
                  $display("FAIL inv_write step%0d slot%0d: got hit=%b target=%h, expected hit=%b target=%h",
                           k, i, btb_bus.btb_hits[i], btb_bus.btb_targets[i], e.hits[i], e.tg[i]);
               end
            end
         end
      end
   endtask

   task automatic test_all_slots_reset();
      step_t s[$];
      exp_t  e;
      // Highest set (31); the reset cycle also carries a write that must be dropped.
      s.push_back(wr(32'h07C, 32'hDEADBEEC));
      s.push_back(lk(p4(32'h07C, 32'h07C, 32'h07E, 32'h17C), 4'b0111,
                     p4(32'hDEADBEEC, 32'hDEADBEEC, 32'hDEADBEEC, 32'h0)));
      s.push_back(st(1'b1, '0, 1'b1, 32'h17C, 32'h999, 1'b0, '0, 1'b0, '0, '0));
      s.push_back(lk(p4(32'h07C, 32'h100, 32'h1C4, 32'h17C), 4'b0000, '0));
      foreach (s[k]) begin
         apply(s[k]);
         @(negedge clock);
         if (s[k].chk) begin
            e = sb.pop_front();
            for (int i = 0; i < N; i++) begin
               n_cmp++;
               if (btb_bus.btb_hits[i] !== e.hits[i] || btb_bus.btb_targets[i] !== e.tg[i]) begin
                  n_bad++;
                  $display("FAIL all_slots_reset step%0d slot%0d: got hit=%b target=%h, expected hit=%b target=%h",
                           k, i, btb_bus.btb_hits[i], btb_bus.btb_targets[i], e.hits[i], e.tg[i]);
               end
            end
         end
      end
   endtask

   initial begin
      btb_bus.PCs_out   = '0;
      btb_bus.wr_valid  = 1'b0;
      btb_bus.wr_PC     = '0;
      btb_bus.wr_target = '0;
      btb_bus.inv_valid = 1'b0;
      btb_bus.inv_PC    = '0;
      test_reset();
      test_write_visibility();
      test_replacement();
      test_update_in_place();
      test_inv_write();
      test_all_slots_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
